hls_frame_sequencer: RTL
========================

// Module: hls_frame_sequencer
// PURPOSE
//  Sequences an ap_ctrl_hs-style HLS core (ap_start/ap_done/ap_idle/ap_ready, one data word in, one out)
//  over a frame of FRAME_LEN pixels. Takes pixels from a valid/ready input stream and issues one core
//  start per pixel. Captures each core result and emits it on a valid/ready output stream.
//  Sits between the pixel source (image loader/DMA) and the HLS compute core; flags core hangs.
// PARAMETERS
//  DATA_W     8    pixel and result width (bits)
//  FRAME_LEN  10   pixels per frame; legal range 1 .. 2**CNT_W-1
//  CNT_W      16   pixel counter width
//  TIMEOUT    255  max cycles in WAIT before error; legal range 1 .. 2**TO_W-1
//  TO_W       8    timeout counter width
// PORTS
//  ap_clk      in   1       clock, all logic on rising edge
//  ap_rst_n    in   1       asynchronous active-low reset
//  cfg_start   in   1       pulse: begin a frame (honoured only in IDLE)
//  cfg_abort   in   1       level/pulse: abandon frame, return to IDLE
//  busy        out  1       1 in any state other than IDLE
//  frame_done  out  1       one-cycle pulse after last pixel accepted downstream
//  err_timeout out  1       sticky: core did not finish within TIMEOUT; cleared by cfg_start or reset
//  pix_cnt     out  CNT_W   pixels completed in current frame
//  in_data     in   DATA_W  input pixel
//  in_valid    in   1       input pixel valid
//  in_ready    out  1       sequencer accepts pixel
//  core_start  out  1       to core ap_start
//  core_ready  in   1       from core ap_ready
//  core_idle   in   1       from core ap_idle
//  core_done   in   1       from core ap_done (may be level; treated as level)
//  core_din    out  DATA_W  to core input_data
//  core_dout   in   DATA_W  from core output_data
//  out_data    out  DATA_W  result pixel
//  out_valid   out  1       result valid
//  out_ready   in   1       downstream accepts result
// BEHAVIOUR
//  Reset (async, ap_rst_n=0): state=IDLE. busy, frame_done, err_timeout, in_ready, core_start and
//   out_valid =0. pix_cnt, core_din and out_data =0. Internal registers also 0.
//  States IDLE, LOAD, ISSUE, WAIT, EMIT, DONE. Outputs are decoded from registered state; no comb path
//   in->out except in_ready/out_valid, which follow state.
//  IDLE: cfg_start=1 -> LOAD; pix_cnt<=0, err_timeout<=0.
//  LOAD: in_ready=1. On in_valid&in_ready, core_din<=in_data -> ISSUE.
//  ISSUE: core_start=1. If core_ready&core_idle are sampled -> WAIT and to_cnt<=0. core_start is low
//   from the next cycle, so exactly one start cycle per pixel. Otherwise stay in ISSUE with core_start held.
//  WAIT: core_start=0. core_done is sampled only here; first sample is the cycle after the handshake.
//   - core_done=1: out_data<=core_dout -> EMIT.
//   - Otherwise to_cnt++. When to_cnt reaches TIMEOUT-1 without done: err_timeout<=1 -> IDLE, with no
//     frame_done and pix_cnt frozen.
//   core_din holds stable from ISSUE until WAIT exits.
//  EMIT: out_valid=1, with out_data stable until accepted. On out_ready, pix_cnt<=pix_cnt+1;
//   if pix_cnt==FRAME_LEN-1 -> DONE, else LOAD. Zero-bubble is not required; a pixel takes >=4 cycles.
//  DONE: frame_done=1 for one cycle -> IDLE.
//  cfg_abort=1 in any state beats all other transitions -> IDLE next cycle.
//   in_ready, core_start and out_valid drop that cycle. No frame_done; pix_cnt and err_timeout hold.
//  cfg_start while busy is ignored. cfg_start and cfg_abort together in IDLE: abort wins, stay IDLE.
//  FRAME_LEN=1: LOAD, ISSUE, WAIT, EMIT, then DONE directly.
// TESTING
//  1 Frame: FRAME_LEN=10, pixels 0x00..0x09, echo core with done 1 cycle after start, out_ready=1.
//    Required: out_data 0x00..0x09 in order, pix_cnt=10, one frame_done pulse, err_timeout=0.
//  2 Backpressure: out_ready low for 5 cycles at pixel 3 (0xA5).
//    Required: out_valid held, out_data=0xA5 stable, no in_ready, no core_start until accepted.
//  3 Core not ready: core_idle=0 for 7 cycles at ISSUE.
//    Required: core_start high 7 cycles, exactly one start after idle rises, core_din constant.
//  4 Hang: core_done never rises, TIMEOUT=255.
//    Required: err_timeout=1 exactly 255 cycles after WAIT entry, busy=0, no frame_done, pix_cnt unchanged.
//    A following cfg_start clears err_timeout.
//  5 Abort in WAIT at pixel 4, then new cfg_start.
//    Required: IDLE next cycle, pix_cnt=4, no frame_done. New frame restarts pix_cnt=0 and completes.
//  6 Async reset mid-EMIT (ap_rst_n low 3 ns, off clock edge).
//    Required: all outputs 0 immediately, busy=0, a later frame runs correctly.

Source files
------------

// File: rtl/hls_frame_sequencer.sv
// hls_frame_sequencer: drives an ap_ctrl_hs HLS core once per pixel of a frame.
// Pixels come in on a valid/ready stream and results leave on another one.
// A per-pixel watchdog flags a core that never raises ap_done.
module hls_frame_sequencer #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  pix_cnt,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_idle,
    input  logic              core_done,
    output logic [DATA_W-1:0] core_din,
    input  logic [DATA_W-1:0] core_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_EMIT, S_DONE
    } state_t;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state, state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic             core_hs;
    logic             to_expired;

    assign core_hs    = core_ready && core_idle;
    assign to_expired = (to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state and state-decoded outputs; abort overrides every transition
    // and masks the handshake strobes in the same cycle.
    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE:  if (cfg_start) state_nxt = S_LOAD;
            S_LOAD: begin
                in_ready = !cfg_abort;
                if (in_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                core_start = !cfg_abort;
                if (core_hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done)       state_nxt = S_EMIT;
                else if (to_expired) state_nxt = S_IDLE;
            end
            S_EMIT: begin
                out_valid = !cfg_abort;
                if (out_ready) state_nxt = (pix_cnt == PIX_LAST) ? S_DONE : S_LOAD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_abort) state_nxt = S_IDLE;
    end

    // Datapath registers: pixel latch, result latch, counters and sticky error.
    // Nothing moves on an abort cycle so pix_cnt and err_timeout hold.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pix_cnt     <= '0;
            err_timeout <= 1'b0;
            core_din    <= '0;
            out_data    <= '0;
            to_cnt      <= '0;
        end else if (!cfg_abort) begin
            case (state)
                S_IDLE: if (cfg_start) begin
                    pix_cnt     <= '0;
                    err_timeout <= 1'b0;
                end
                S_LOAD:  if (in_valid) core_din <= in_data;
                S_ISSUE: if (core_hs) to_cnt <= '0;
                S_WAIT: begin
                    if (core_done)       out_data    <= core_dout;
                    else if (to_expired) err_timeout <= 1'b1;
                    else                 to_cnt      <= to_cnt + TO_W'(1);
                end
                S_EMIT:  if (out_ready) pix_cnt <= pix_cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
